pipeline_sub32: RTL and testbench

Four-stage pipelined 32-bit subtractor computing `DIFF = num_a - num_b - Bin` one byte per stage, with a borrow chain between stages. It is the subtract counterpart of the team's pipelined 32-bit adder and feeds the same datapath. Unlike a bare carry pipeline, it carries a valid/ready handshake. Operand bytes are skewed on entry and result bytes de-skewed on exit, so back-to-back transactions stay coherent under backpressure.

---
 rtl/pipeline_sub32.sv | 72 +++++++
 tb/tb_pipeline_sub32.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pipeline_sub32.sv
// pipeline_sub32: four-slice byte-serial 32-bit subtractor with valid/ready handshake.
module pipeline_sub32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] num_a,
    input  logic [31:0] num_b,
    input  logic        Bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] DIFF,
    output logic        Bout,
    output logic        V
);
    logic        adv;
    logic [3:0]  v, c;
    logic [31:0] a0, b0;
    logic [31:8] a1, b1;
    logic [31:16] a2, b2;
    logic [31:24] a3, b3;
    logic [7:0]  r1;
    logic [15:0] r2;
    logic [23:0] r3;
    logic [8:0]  s0, s1, s2, s3;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    // each slice adds a + ~b + carry; carry is the inverted borrow
    assign s0 = {1'b0, a0[7:0]}   + {1'b0, ~b0[7:0]}   + {8'd0, c[0]};
    assign s1 = {1'b0, a1[15:8]}  + {1'b0, ~b1[15:8]}  + {8'd0, c[1]};
    assign s2 = {1'b0, a2[23:16]} + {1'b0, ~b2[23:16]} + {8'd0, c[2]};
    assign s3 = {1'b0, a3[31:24]} + {1'b0, ~b3[31:24]} + {8'd0, c[3]};
    always_ff @(posedge clk) begin
        if (reset) begin
            v         <= '0;
            c         <= '0;
            a0        <= '0;
            b0        <= '0;
            a1        <= '0;
            b1        <= '0;
            a2        <= '0;
            b2        <= '0;
            a3        <= '0;
            b3        <= '0;
            r1        <= '0;
            r2        <= '0;
            r3        <= '0;
            out_valid <= 1'b0;
            DIFF      <= '0;
            Bout      <= 1'b0;
            V         <= 1'b0;
        end else if (adv) begin
            v         <= {v[2:0], in_valid};
            c         <= {s2[8], s1[8], s0[8], ~Bin};
            a0        <= num_a;
            b0        <= num_b;
            a1        <= a0[31:8];
            b1        <= b0[31:8];
            a2        <= a1[31:16];
            b2        <= b1[31:16];
            a3        <= a2[31:24];
            b3        <= b2[31:24];
            r1        <= s0[7:0];
            r2        <= {s1[7:0], r1};
            r3        <= {s2[7:0], r2};
            out_valid <= v[3];
            DIFF      <= {s3[7:0], r3};
            Bout      <= ~s3[8];
            V         <= (a3[31] ^ b3[31]) & (s3[7] ^ a3[31]);
        end
    end
endmodule

// File: tb/tb_pipeline_sub32.sv
// tb_pipeline_sub32: directed and scoreboarded checks of the pipelined subtractor.
module tb_pipeline_sub32;
    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready, Bin;
    logic [31:0] num_a, num_b;
    logic        in_ready, out_valid, Bout, V;
    logic [31:0] DIFF;
    int checks = 0;
    int errors = 0;

    pipeline_sub32 dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .num_a(num_a), .num_b(num_b), .Bin(Bin), .out_valid(out_valid),
        .out_ready(out_ready), .DIFF(DIFF), .Bout(Bout), .V(V)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // returns {V, Bout, DIFF}
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [32:0] t;
        t = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        return {(a[31] ^ b[31]) & (t[31] ^ a[31]), t};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b, input logic bin,
                           input logic [31:0] ed, input logic eb, input logic ev);
        int n;
        num_a = a; num_b = b; Bin = bin; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick;
            n++;
        end
        check({tag, "_lat"}, n, 4);
        check({tag, "_diff"}, DIFF, ed);
        check({tag, "_bout"}, {31'd0, Bout}, {31'd0, eb});
        check({tag, "_v"}, {31'd0, V}, {31'd0, ev});
        tick;
    endtask

    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic        vbin [8];
    logic [33:0] exq [$];
    logic [33:0] e;
    logic        seen, acc, emit, stall_started;
    int          sent, got, stall;

    initial begin
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        num_a = 32'd5; num_b = 32'd3; Bin = 1'b0;
        tick;
        tick;
        check("rst_ov", {31'd0, out_valid}, 32'd0);
        check("rst_diff", DIFF, 32'd0);
        check("rst_bout", {31'd0, Bout}, 32'd0);
        check("rst_v", {31'd0, V}, 32'd0);
        check("rst_ir", {31'd0, in_ready}, 32'd1);
        reset = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            tick;
            seen |= out_valid;
        end
        check("rst_noemit", {31'd0, seen}, 32'd0);

        run_one("basic", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        run_one("ripple", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_one("binr", 32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0000_00FF, 1'b0, 1'b0);
        run_one("ovf1", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_one("ovf2", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1);

        for (int i = 0; i < 8; i++) begin
            va[i] = $urandom; vb[i] = $urandom; vbin[i] = 1'($urandom_range(1));
        end
        sent = 0; got = 0; stall = 0; stall_started = 1'b0;
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
            in_valid = sent < 8;
            if (sent < 8) begin
                num_a = va[sent]; num_b = vb[sent]; Bin = vbin[sent];
            end
            if (out_valid && !stall_started) begin
                stall_started = 1'b1;
                stall = 3;
            end
            out_ready = stall == 0;
            #1;
            acc  = in_valid && in_ready;
            emit = out_valid && out_ready;
            if (stall > 0) begin
                check("stall_ir", {31'd0, in_ready}, 32'd0);
                check("stall_ov", {31'd0, out_valid}, 32'd1);
                check("stall_diff", DIFF, exq[0][31:0]);
            end
            if (emit) begin
                e = exq.pop_front();
                check("b2b_diff", DIFF, e[31:0]);
                check("b2b_bout", {31'd0, Bout}, {31'd0, e[32]});
                check("b2b_v", {31'd0, V}, {31'd0, e[33]});
                got++;
            end
            if (acc) begin
                exq.push_back(model(num_a, num_b, Bin));
                sent++;
            end
            tick;
            if (stall > 0) stall--;
        end
        check("b2b_cnt", got, 8);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("b2b_drain", {31'd0, out_valid}, 32'd0);

        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            num_a = 32'h1000 + i; num_b = 32'h10; Bin = 1'b0;
            reset = i == 2;
            tick;
        end
        reset = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            seen |= out_valid;
            tick;
        end
        check("mid_noemit", {31'd0, seen}, 32'd0);
        run_one("mid", 32'h1234_5678, 32'h0234_5679, 1'b0, 32'h0FFF_FFFF, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
